// File: rtl/mul_cmd_ctrl_pkg.sv
// Shared types and constants for the multiplier command controller.
package mul_ctrl_pkg;

  localparam int OPND_W      = 32;
  localparam int RES_W       = 64;
  localparam int TIMEOUT_DEF = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/mul_cmd_ctrl_if.sv
// Host-side command/response channel and core-side control bundle.
interface mul_cmd_if import mul_ctrl_pkg::*; ();
  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] in_a;
  logic [OPND_W-1:0] in_b;
  logic              abort;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_result;
  logic              out_err;
  logic              busy;

  // Front end issuing commands and consuming responses.
  modport master (
    output in_valid, in_a, in_b, abort, out_ready,
    input  in_ready, out_valid, out_result, out_err, busy
  );

  // Controller serving commands.
  modport slave (
    input  in_valid, in_a, in_b, abort, out_ready,
    output in_ready, out_valid, out_result, out_err, busy
  );
endinterface

interface mul_core_if import mul_ctrl_pkg::*; ();
  logic              op_start;
  logic              op_clear;
  logic [OPND_W-1:0] op_a;
  logic [OPND_W-1:0] op_b;
  logic              op_done;
  logic [RES_W-1:0]  op_result;

  // Controller driving the multiplier core.
  modport master (
    output op_start, op_clear, op_a, op_b,
    input  op_done, op_result
  );

  // Multiplier core side.
  modport slave (
    input  op_start, op_clear, op_a, op_b,
    output op_done, op_result
  );
endinterface

// File: rtl/mul_cmd_ctrl_cla8.sv
// 8-bit carry-lookahead adder; every carry is formed directly from g/p/cin.
module cla8 (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  assign c[0] = cin_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign g[gi]     = a_i[gi] & b_i[gi];
    assign p[gi]     = a_i[gi] ^ b_i[gi];
    assign sum_o[gi] = p[gi] ^ c[gi];

    // Flattened lookahead carry into bit gi+1.
    always_comb begin
      logic term;
      logic carry;
      term  = 1'b0;
      carry = cin_i & (&p[gi:0]);
      for (int j = 0; j <= gi; j++) begin
        term = g[j];
        for (int k = j + 1; k <= gi; k++) begin
          term = term & p[k];
        end
        carry = carry | term;
      end
      c[gi+1] = carry;
    end
  end

  assign cout_o = c[8];

endmodule

// File: rtl/mul_cmd_ctrl.sv
// Command-side controller for the 32-cycle multiplier core: accepts an operand
// pair, launches the core, waits for done/timeout, clears it, returns product.
module mul_cmd_ctrl import mul_ctrl_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_DEF,  // 2..63
  parameter int CNT_W   = 6             // 1..7, wide enough for TIMEOUT-1
) (
  input logic       clk,
  input logic       reset,
  mul_cmd_if.slave  cmd,
  mul_core_if.master core
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [OPND_W-1:0] a_q, a_d;
  logic [OPND_W-1:0] b_q, b_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              op_start_q, op_start_d;
  logic              op_clear_q, op_clear_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  // Saturating counter increment through the shared 8-bit adder.
  logic [7:0]       cnt_ext;
  logic [7:0]       cnt_sum;
  logic             cnt_cout;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_inc;

  // Zero-extend the counter onto the adder input.
  always_comb begin
    cnt_ext            = '0;
    cnt_ext[CNT_W-1:0] = cnt_q;
  end

  cla8 u_cnt_inc (
    .a_i   (cnt_ext),
    .b_i   (8'd0),
    .cin_i (1'b1),
    .sum_o (cnt_sum),
    .cout_o(cnt_cout)
  );

  // Any carry past the counter width means it is already all-ones: hold it.
  assign cnt_sat = cnt_cout | (|cnt_sum[7:CNT_W]);
  assign cnt_inc = cnt_sat ? cnt_q : cnt_sum[CNT_W-1:0];

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd.in_valid) begin
          a_d     = cmd.in_a;
          b_d     = cmd.in_b;
          abort_d = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = '0;
        if (cmd.abort) begin
          abort_d = 1'b1;
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        // abort beats done, and done on the last cycle still succeeds
        if (cmd.abort) begin
          abort_d = 1'b1;
          state_d = ST_CLEAR;
        end else if (core.op_done) begin
          result_d = core.op_result;
          err_d    = 1'b0;
          state_d  = ST_CLEAR;
        end else if (cnt_q == TMO_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        abort_d = 1'b0;
        state_d = abort_q ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        if (cmd.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register with it.
    op_start_d  = (state_d == ST_START);
    op_clear_d  = (state_d == ST_CLEAR);
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, data and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      op_start_q  <= 1'b0;
      op_clear_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      op_start_q  <= op_start_d;
      op_clear_q  <= op_clear_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd.in_ready   = in_ready_q;
  assign cmd.out_valid  = out_valid_q;
  assign cmd.out_result = result_q;
  assign cmd.out_err    = err_q;
  assign cmd.busy       = busy_q;
  assign core.op_start  = op_start_q;
  assign core.op_clear  = op_clear_q;
  assign core.op_a      = a_q;
  assign core.op_b      = b_q;

endmodule

// File: tb/tb_mul_cmd_ctrl.sv
// Self-checking bench for mul_cmd_ctrl: directed and random operations checked
// cycle by cycle against a timeline derived from the operation rules.
module tb_mul_cmd_ctrl;
  import mul_ctrl_pkg::*;

  localparam int TMO = 40;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mul_cmd_if  cmd ();
  mul_core_if core ();

  mul_cmd_ctrl #(.TIMEOUT(TMO), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .cmd  (cmd),
    .core (core)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive_quiet();
    cmd.in_valid   = 1'b0;
    cmd.in_a       = '0;
    cmd.in_b       = '0;
    cmd.abort      = 1'b0;
    cmd.out_ready  = 1'b0;
    core.op_done   = 1'b0;
    core.op_result = '0;
  endtask

  task automatic chk_reset_state(input string where);
    chk({where, ":in_ready"},   cmd.in_ready,   1);
    chk({where, ":out_valid"},  cmd.out_valid,  0);
    chk({where, ":out_result"}, cmd.out_result, 0);
    chk({where, ":out_err"},    cmd.out_err,    0);
    chk({where, ":busy"},       cmd.busy,       0);
    chk({where, ":op_start"},   core.op_start,  0);
    chk({where, ":op_clear"},   core.op_clear,  0);
    chk({where, ":op_a"},       core.op_a,      0);
    chk({where, ":op_b"},       core.op_b,      0);
  endtask

  // One operation. Called at posedge+1 of an IDLE cycle (cycle 0); returns at
  // posedge+1 of the first IDLE cycle afterwards. done_c/abort_c are the cycles
  // at which the core model raises op_done / the host raises abort (0 = never).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int done_c, input int abort_c, input int hold);
    logic [63:0] prod;
    logic [63:0] exp_res;
    bit          done_ok, aborted, err, exp_idle, exp_ov;
    int          t_end, t, m, c_last;

    prod    = {32'd0, a} * {32'd0, b};
    done_ok = (done_c >= 2) && (done_c <= TMO + 1);
    t_end   = done_ok ? done_c : TMO + 1;
    aborted = (abort_c >= 1) && (abort_c <= t_end);
    t       = aborted ? abort_c : t_end;
    err     = !aborted && !done_ok;
    exp_res = err ? 64'd0 : prod;
    m       = t + 2 + hold;
    c_last  = aborted ? t + 2 : m + 1;

    chk("handshake:in_ready", cmd.in_ready, 1);
    cmd.in_valid = 1'b1;
    cmd.in_a     = a;
    cmd.in_b     = b;
    @(posedge clk); #1;

    for (int c = 1; c <= c_last; c++) begin
      exp_idle = aborted ? (c >= t + 2) : (c >= m + 1);
      exp_ov   = !aborted && (c >= t + 2) && (c <= m);
      chk($sformatf("op_start@%0d", c),  core.op_start, (c == 1));
      chk($sformatf("op_clear@%0d", c),  core.op_clear, (c == t + 1));
      chk($sformatf("in_ready@%0d", c),  cmd.in_ready,  exp_idle);
      chk($sformatf("busy@%0d", c),      cmd.busy,      !exp_idle);
      chk($sformatf("out_valid@%0d", c), cmd.out_valid, exp_ov);
      if (exp_ov) begin
        chk($sformatf("out_result@%0d", c), cmd.out_result, exp_res);
        chk($sformatf("out_err@%0d", c),    cmd.out_err,    err);
      end
      if (c <= t + 1) begin
        chk($sformatf("op_a@%0d", c), core.op_a, a);
        chk($sformatf("op_b@%0d", c), core.op_b, b);
      end
      if (c == c_last) break;
      // Noise on the input channel while busy must not disturb anything.
      cmd.in_valid   = 1'($urandom_range(0, 1));
      cmd.in_a       = $urandom;
      cmd.in_b       = $urandom;
      core.op_done   = (c == done_c);
      core.op_result = (c == done_c) ? prod : {$urandom, $urandom};
      cmd.abort      = (c == abort_c);
      cmd.out_ready  = !aborted && (c >= m);
      @(posedge clk); #1;
    end
    drive_quiet();
    $display("txn a=%h b=%h done@%0d abort@%0d hold=%0d -> %s result=%h",
             a, b, done_c, abort_c, hold,
             aborted ? "aborted" : (err ? "timeout" : "ok"), exp_res);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_quiet();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_reset_state("reset");

    // normal small product
    run_op(32'h0000_0003, 32'h0000_0005, 34, 0, 0);
    // largest operands, response held 5 cycles
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 20, 0, 5);
    // core never answers: timeout
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 0, 0, 0);
    // abort mid-BUSY
    run_op(32'h0000_0007, 32'h0000_0009, 34, 10, 0);
    // abort together with done: abort wins
    run_op(32'h0000_0011, 32'h0000_0013, 15, 15, 0);
    // done on the timeout cycle succeeds
    run_op(32'hDEAD_BEEF, 32'h0000_0002, TMO + 1, 0, 1);
    // abort during START
    run_op(32'h0000_0100, 32'h0000_0200, 30, 1, 0);
    // done during START is ignored, ends in timeout
    run_op(32'h0000_0021, 32'h0000_0003, 1, 0, 2);

    // reset in the middle of BUSY, then a clean operation
    cmd.in_valid = 1'b1;
    cmd.in_a     = 32'hCAFE_0001;
    cmd.in_b     = 32'h0000_0010;
    @(posedge clk); #1;
    cmd.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("midbusy:busy", cmd.busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_reset_state("midreset");
    $display("txn reset asserted at cycle 20 of an in-flight operation");
    run_op(32'h0000_0006, 32'h0000_0007, 34, 0, 0);

    // random operations
    for (int i = 0; i < 10; i++) begin
      int d, ab, h;
      d  = $urandom_range(0, TMO + 5);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, TMO + 5) : 0;
      h  = $urandom_range(0, 3);
      run_op($urandom, $urandom, d, ab, h);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_cmd_ctrl.md
# mul_cmd_ctrl

Command-side controller for the 32-cycle multiplier core: it drives `op_start`/`op_clear` and consumes `op_done`/`result`. It accepts operand pairs over a valid/ready input channel, launches one multiplication, waits for completion or timeout, clears the core, and returns the 64-bit product over a valid/ready output channel. It sits between the bus/register front end and the multiplier core.

## Interface
- `TIMEOUT`, 40, number of BUSY cycles without `op_done` before the operation is aborted (must be 2..63)
- `CNT_W`, 6, timeout counter width
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  controller can accept operands
- `in_a`  in  32  multiplicand
- `in_b`  in  32  multiplier
- `abort`  in  1  cancel in-flight operation, no response
- `out_valid`  out  1  response present
- `out_ready`  in  1  consumer accepts response
- `out_result`  out  64  product (all-zero on error)
- `out_err`  out  1  response is a timeout error
- `busy`  out  1  state is not IDLE
- `op_start`  out  1  start pulse to core
- `op_clear`  out  1  clear pulse to core
- `op_a`, `op_b`  out  32 each  registered operands to core
- `op_done`  in  1  core completion
- `op_result`  in  64  core product, valid while `op_done`=1

## Operation
- Reset values: state IDLE, `in_ready`=1, every other output 0, operand/result registers and counter 0.
- States:
  - IDLE: `in_ready`=1. On `in_valid`: latch `op_a`/`op_b`, go to START.
  - START: `op_start`=1 for exactly one cycle, counter cleared, go to BUSY.
  - BUSY: the counter increments each cycle.
    - If `op_done`=1: capture `op_result`, `out_err`=0, go to CLEAR.
    - Else if counter == `TIMEOUT`-1: result 0, `out_err`=1, go to CLEAR.
  - CLEAR: `op_clear`=1 for exactly one cycle. Go to RESP, or to IDLE if the abort flag is set.
  - RESP: `out_valid`=1, holding `out_result`/`out_err` stable. When `out_ready`=1, go to IDLE.
- `abort` in START or BUSY: set the abort flag and go to CLEAR. No response is produced. `abort` is ignored in IDLE, CLEAR and RESP.
- Priority in BUSY: `abort` > `op_done` > timeout. If `op_done` arrives on the timeout cycle, the operation succeeds.
- `op_start` and `op_clear` are never asserted in the same cycle.
- `op_a`/`op_b` stay stable from START through CLEAR.
- `op_done` outside BUSY is ignored.
- Counter is `CNT_W` bits, unsigned, and saturates. It never wraps, because it only counts in BUSY and `TIMEOUT` ≤ 63.

## Timing
- Input handshake completes at cycle 0 (`in_valid` & `in_ready`).
- Cycle 1: `op_start`=1. Cycle 2: first BUSY cycle.
- `op_done` sampled at cycle k → `op_clear`=1 at cycle k+1 → `out_valid`=1 from cycle k+2.
- Timeout: BUSY occupies cycles 2..TIMEOUT+1; `op_clear` at TIMEOUT+2; `out_valid` at TIMEOUT+3.
- Output handshake at cycle m → IDLE at m+1, `in_ready`=1 at m+1. Throughput: one operation in flight, no overlap.
- `reset` mid-operation returns everything to reset values on the next edge. `op_clear` is not issued; the core shares the same reset.

## Structure
- Shared package `mul_ctrl_pkg` holds:
  - 3-bit state encoding: IDLE=0, START=1, BUSY=2, CLEAR=3, RESP=4
  - operand width 32 and result width 64
  - default `TIMEOUT`
- Two processes: a state/data register process and a combinational next-state/output process.
- Counter increment uses the existing `cla8` adder instance. No other sub-module.

## Test plan
- Normal: `in_a`=0x0000_0003, `in_b`=0x0000_0005; core model asserts `op_done` at cycle 34 with 15 → `op_start` at cycle 1, `op_clear` at 35, `out_valid` at 36, `out_result`=15, `out_err`=0.
- Large values: `in_a`=`in_b`=0xFFFF_FFFF → `out_result`=0xFFFF_FFFE_0000_0001. Hold `out_ready`=0 for 5 cycles → output stays stable and `in_ready`=0 throughout.
- Timeout: core never asserts `op_done`, `TIMEOUT`=40 → `op_clear` at 42, `out_valid` at 43, `out_err`=1, `out_result`=0.
- Abort: `abort`=1 at cycle 10 → `op_clear` at 11, no `out_valid`, `in_ready`=1 at 12. Also, `abort` and `op_done` together → no response.
- Done on timeout cycle: `op_done`=1 exactly at cycle 41 → `out_err`=0 and result captured.
- Reset mid-BUSY: `reset`=1 at cycle 20 → all outputs 0 and `in_ready`=1 next edge. A new operation afterwards completes normally.
